ras_ctrl: RTL and testbench

Speculative control and repair sequencer for the return address stack (RAS) storage array in the IFU branch predictor. It owns the RAS top-of-stack pointer and drives the storage write port. It applies predicted calls and returns at fetch and records a checkpoint per fetched control-flow instruction. On an execute-stage redirect it restores pointer and top entry from that checkpoint, then replays the actual call or return.

---
 rtl/ras_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ras_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
// Return address stack pointer and checkpoint controller: speculative push/pop at fetch,
// checkpoint restore plus a one-cycle replay of the true call on an execute redirect.
module ras_ctrl #(
    parameter int RAS_SIZE   = 16,
    parameter int XLEN       = 64,
    parameter int CKPT_DEPTH = 8,
    localparam int D = $clog2(RAS_SIZE),
    localparam int T = $clog2(CKPT_DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            CtrlF,
    input  logic            PredCallF,
    input  logic            PredReturnF,
    input  logic            StallF,
    input  logic [XLEN-1:0] PCLinkF,
    input  logic [XLEN-1:0] RASTopF,
    input  logic            ResolveE,
    input  logic [T-1:0]    ResolveTagE,
    input  logic            RedirectE,
    input  logic [T-1:0]    RedirectTagE,
    input  logic            ActualCallE,
    input  logic            ActualReturnE,
    input  logic [XLEN-1:0] PCLinkE,
    output logic [D-1:0]    Ptr,
    output logic [XLEN-1:0] RASPCF,
    output logic [T-1:0]    CkptTagF,
    output logic            StallReqF,
    output logic            RASWrEn,
    output logic [D-1:0]    RASWrIdx,
    output logic [XLEN-1:0] RASWrData
);

    typedef enum logic {ST_IDLE = 1'b0, ST_REPAIR = 1'b1} state_t;

    state_t          r_state;
    logic [D-1:0]    r_ptr;
    logic [D-1:0]    r_rep_ptr;
    logic [XLEN-1:0] r_rep_link;
    logic [T-1:0]    r_head;
    logic [T-1:0]    r_tail;
    logic [T:0]      r_count;
    logic [D-1:0]    r_ckpt_ptr [CKPT_DEPTH];
    logic [XLEN-1:0] r_ckpt_tos [CKPT_DEPTH];

    logic            w_idle;
    logic            w_full;
    logic            w_redirect;
    logic            w_fetch;
    logic            w_resolve;
    logic [D-1:0]    w_c_ptr;
    logic [XLEN-1:0] w_c_tos;
    logic [T-1:0]    w_head_nxt;
    logic [T-1:0]    w_tag_dist;
    logic [T-1:0]    w_tail_nxt;
    logic [T:0]      w_count_nxt;
    logic            w_wr_en;
    logic [D-1:0]    w_wr_idx;
    logic [XLEN-1:0] w_wr_data;

    // Explicit wrap keeps non-power-of-2 stacks correct.
    function automatic logic [D-1:0] ptr_inc(input logic [D-1:0] p);
        if (p == D'(RAS_SIZE - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + D'(1);
        end
    endfunction

    function automatic logic [D-1:0] ptr_dec(input logic [D-1:0] p);
        if (p == '0) begin
            ptr_dec = D'(RAS_SIZE - 1);
        end else begin
            ptr_dec = p - D'(1);
        end
    endfunction

    assign w_idle     = ~reset & (r_state == ST_IDLE);
    assign w_full     = (r_count == (T+1)'(CKPT_DEPTH));
    assign w_redirect = w_idle & RedirectE;
    assign w_fetch    = w_idle & CtrlF & ~StallF & ~RedirectE & ~w_full;
    assign w_resolve  = ~reset & ResolveE & (ResolveTagE == r_head) & (r_count != '0);
    assign w_c_ptr    = r_ckpt_ptr[RedirectTagE];
    assign w_c_tos    = r_ckpt_tos[RedirectTagE];
    assign w_head_nxt = w_resolve ? (r_head + T'(1)) : r_head;
    assign w_tag_dist = RedirectTagE - w_head_nxt;

    // Next checkpoint tail and occupancy; a redirect trims everything younger than its tag.
    always_comb begin
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (w_redirect) begin
            w_tail_nxt  = RedirectTagE + T'(1);
            w_count_nxt = {1'b0, w_tag_dist} + (T+1)'(1);
        end else if (w_fetch) begin
            w_tail_nxt  = r_tail + T'(1);
            w_count_nxt = w_resolve ? r_count : (r_count + (T+1)'(1));
        end else begin
            w_count_nxt = w_resolve ? (r_count - (T+1)'(1)) : r_count;
        end
    end

    // Storage write port: repair replay, TOS restore, or speculative call push.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = '0;
        w_wr_data = '0;
        if (reset) begin
            w_wr_en = 1'b0;
        end else if (r_state == ST_REPAIR) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = r_rep_ptr;
            w_wr_data = r_rep_link;
        end else if (w_redirect) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = w_c_ptr;
            w_wr_data = w_c_tos;
        end else if (w_fetch && PredCallF) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = ptr_inc(r_ptr);
            w_wr_data = PCLinkF;
        end else begin
            w_wr_en = 1'b0;
        end
    end

    // Control FSM: pointer, FIFO indices and the pending call replay.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_rep_ptr  <= '0;
            r_rep_link <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (RedirectE) begin
                        if (ActualCallE) begin
                            r_ptr      <= w_c_ptr;
                            r_rep_ptr  <= ptr_inc(w_c_ptr);
                            r_rep_link <= PCLinkE;
                            r_state    <= ST_REPAIR;
                        end else if (ActualReturnE) begin
                            r_ptr <= ptr_dec(w_c_ptr);
                        end else begin
                            r_ptr <= w_c_ptr;
                        end
                    end else if (w_fetch) begin
                        if (PredCallF) begin
                            r_ptr <= ptr_inc(r_ptr);
                        end else if (PredReturnF) begin
                            r_ptr <= ptr_dec(r_ptr);
                        end
                    end
                end
                ST_REPAIR: begin
                    r_ptr   <= r_rep_ptr;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Checkpoint capture of pointer and top entry for every allocated fetch.
    always_ff @(posedge clk) begin
        if (w_fetch) begin
            r_ckpt_ptr[r_tail] <= r_ptr;
            r_ckpt_tos[r_tail] <= RASTopF;
        end
    end

    assign Ptr       = r_ptr;
    assign RASPCF    = RASTopF;
    assign CkptTagF  = r_tail;
    assign StallReqF = ~reset & (w_full | (r_state == ST_REPAIR));
    assign RASWrEn   = w_wr_en;
    assign RASWrIdx  = w_wr_idx;
    assign RASWrData = w_wr_data;

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl: directed vector table, a 6-entry wrap sequence, and random traffic
// checked against a queue-based model of the stack and checkpoints.
module tb_ras_ctrl;
    localparam int RS = 16;
    localparam int CD = 8;
    localparam int F_RST = 1, F_CTRL = 2, F_CALL = 4, F_RET = 8;
    localparam int F_RES = 16, F_RED = 32, F_ACALL = 64, F_ARET = 128;

    typedef struct {
        int          flags;
        logic [63:0] linkf;
        logic [2:0]  rtag;
        logic [2:0]  dtag;
        logic [63:0] linke;
        logic [3:0]  e_ptr;
        logic        e_wren;
        logic [3:0]  e_idx;
        logic [63:0] e_data;
        logic        e_stall;
        logic [2:0]  e_tag;
        logic [63:0] e_pcf;
    } vec_t;

    typedef struct {
        logic [2:0]  tag;
        int          p;
        logic [63:0] tos;
    } ck_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_clr;
    logic        ctrl_f, call_f, ret_f, stall_f, res_e, red_e, acall_e, aret_e;
    logic [63:0] link_f, top_f, link_e;
    logic [2:0]  res_tag, red_tag;
    logic [3:0]  ptr, wr_idx;
    logic [63:0] pcf, wr_data;
    logic [2:0]  tag_f;
    logic        stall_req, wr_en;
    logic [63:0] mem [RS];

    logic        s6_reset, s6_ctrl, s6_call, s6_ret, s6_res;
    logic [63:0] s6_link, s6_top, s6_pcf, s6_wrdata;
    logic [2:0]  s6_ptr, s6_wridx, s6_tag;
    logic        s6_stallreq, s6_wren;
    logic [63:0] mem6 [8];

    int n_checks = 0;
    int n_errors = 0;

    vec_t        vecs[$];
    vec_t        v;
    ck_t         q[$];
    ck_t         c;
    logic [63:0] mmem [RS];
    int          mptr, ntag, mrep_ptr, ridx, e_idx;
    bit          mrep, fire, e_en;
    logic [63:0] mrep_link, e_data;

    ras_ctrl #(.RAS_SIZE(RS), .XLEN(64), .CKPT_DEPTH(CD)) u_dut (
        .clk(clk), .reset(reset), .CtrlF(ctrl_f), .PredCallF(call_f), .PredReturnF(ret_f),
        .StallF(stall_f), .PCLinkF(link_f), .RASTopF(top_f), .ResolveE(res_e),
        .ResolveTagE(res_tag), .RedirectE(red_e), .RedirectTagE(red_tag),
        .ActualCallE(acall_e), .ActualReturnE(aret_e), .PCLinkE(link_e), .Ptr(ptr),
        .RASPCF(pcf), .CkptTagF(tag_f), .StallReqF(stall_req), .RASWrEn(wr_en),
        .RASWrIdx(wr_idx), .RASWrData(wr_data)
    );

    ras_ctrl #(.RAS_SIZE(6), .XLEN(64), .CKPT_DEPTH(CD)) u_dut6 (
        .clk(clk), .reset(s6_reset), .CtrlF(s6_ctrl), .PredCallF(s6_call), .PredReturnF(s6_ret),
        .StallF(1'b0), .PCLinkF(s6_link), .RASTopF(s6_top), .ResolveE(s6_res),
        .ResolveTagE(3'd0), .RedirectE(1'b0), .RedirectTagE(3'd0),
        .ActualCallE(1'b0), .ActualReturnE(1'b0), .PCLinkE(64'h0), .Ptr(s6_ptr),
        .RASPCF(s6_pcf), .CkptTagF(s6_tag), .StallReqF(s6_stallreq), .RASWrEn(s6_wren),
        .RASWrIdx(s6_wridx), .RASWrData(s6_wrdata)
    );

    // Storage arrays behind the write ports; read is combinational at Ptr.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < RS; i++) mem[i] <= 64'h0;
            for (int i = 0; i < 8; i++) mem6[i] <= 64'h0;
        end else begin
            if (wr_en) mem[wr_idx] <= wr_data;
            if (s6_wren) mem6[s6_wridx] <= s6_wrdata;
        end
    end
    assign top_f  = mem[ptr];
    assign s6_top = mem6[s6_ptr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int f, input logic [63:0] lf, input logic [2:0] rt, input logic [2:0] dt,
                       input logic [63:0] le, input logic [3:0] ep, input logic ew, input logic [3:0] ei,
                       input logic [63:0] ed, input logic es, input logic [2:0] et, input logic [63:0] epc);
        vec_t r;
        r.flags = f; r.linkf = lf; r.rtag = rt; r.dtag = dt; r.linke = le;
        r.e_ptr = ep; r.e_wren = ew; r.e_idx = ei; r.e_data = ed; r.e_stall = es;
        r.e_tag = et; r.e_pcf = epc;
        vecs.push_back(r);
    endtask

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        ctrl_f = 1'b0; call_f = 1'b0; ret_f = 1'b0; stall_f = 1'b0; link_f = 64'h0;
        res_e = 1'b0; res_tag = 3'd0; red_e = 1'b0; red_tag = 3'd0;
        acall_e = 1'b0; aret_e = 1'b0; link_e = 64'h0;
        s6_reset = 1'b1; s6_ctrl = 1'b0; s6_call = 1'b0; s6_ret = 1'b0; s6_res = 1'b0; s6_link = 64'h0;

        // Directed table: call/return, checkpoint full, redirect with replay, reset in repair.
        add(F_RST, 64'h0, 3'd0, 3'd0, 64'h0, 4'd0, 1'b0, 4'd0, 64'h0, 1'b0, 3'd0, 64'h0);
        add(0, 64'h0, 3'd0, 3'd0, 64'h0, 4'd0, 1'b0, 4'd0, 64'h0, 1'b0, 3'd0, 64'h0);
        add(F_CTRL|F_CALL, 64'h1004, 3'd0, 3'd0, 64'h0, 4'd0, 1'b1, 4'd1, 64'h1004, 1'b0, 3'd0, 64'h0);
        add(F_CTRL|F_RET, 64'h0, 3'd0, 3'd0, 64'h0, 4'd1, 1'b0, 4'd0, 64'h0, 1'b0, 3'd1, 64'h1004);
        add(0, 64'h0, 3'd0, 3'd0, 64'h0, 4'd0, 1'b0, 4'd0, 64'h0, 1'b0, 3'd2, 64'h0);
        add(F_RST, 64'h0, 3'd0, 3'd0, 64'h0, 4'd0, 1'b0, 4'd0, 64'h0, 1'b0, 3'd0, 64'h0);
        for (int k = 0; k < 8; k++)
            add(F_CTRL|F_CALL, 64'h3000 + 64'(4*k), 3'd0, 3'd0, 64'h0, 4'(k), 1'b1, 4'(k+1),
                64'h3000 + 64'(4*k), 1'b0, 3'(k), (k == 0) ? 64'h0 : 64'h3000 + 64'(4*(k-1)));
        add(F_CTRL|F_CALL, 64'h9999, 3'd0, 3'd0, 64'h0, 4'd8, 1'b0, 4'd0, 64'h0, 1'b1, 3'd0, 64'h301C);
        add(F_RES, 64'h0, 3'd0, 3'd0, 64'h0, 4'd8, 1'b0, 4'd0, 64'h0, 1'b1, 3'd0, 64'h301C);
        add(F_CTRL|F_CALL, 64'h4000, 3'd0, 3'd0, 64'h0, 4'd8, 1'b1, 4'd9, 64'h4000, 1'b0, 3'd0, 64'h301C);
        add(0, 64'h0, 3'd0, 3'd0, 64'h0, 4'd9, 1'b0, 4'd0, 64'h0, 1'b1, 3'd1, 64'h4000);
        add(F_RST, 64'h0, 3'd0, 3'd0, 64'h0, 4'd0, 1'b0, 4'd0, 64'h0, 1'b0, 3'd0, 64'h0);
        add(F_CTRL|F_CALL, 64'h1100, 3'd0, 3'd0, 64'h0, 4'd0, 1'b1, 4'd1, 64'h1100, 1'b0, 3'd0, 64'h0);
        add(F_CTRL|F_RET, 64'h0, 3'd0, 3'd0, 64'h0, 4'd1, 1'b0, 4'd0, 64'h0, 1'b0, 3'd1, 64'h1100);
        add(F_CTRL|F_RET, 64'h0, 3'd0, 3'd0, 64'h0, 4'd0, 1'b0, 4'd0, 64'h0, 1'b0, 3'd2, 64'h0);
        add(F_RED|F_ACALL, 64'h0, 3'd0, 3'd1, 64'h2000, 4'd15, 1'b1, 4'd1, 64'h1100, 1'b0, 3'd3, 64'h0);
        add(0, 64'h0, 3'd0, 3'd0, 64'h0, 4'd1, 1'b1, 4'd2, 64'h2000, 1'b1, 3'd2, 64'h1100);
        add(0, 64'h0, 3'd0, 3'd0, 64'h0, 4'd2, 1'b0, 4'd0, 64'h0, 1'b0, 3'd2, 64'h2000);
        add(F_CTRL|F_CALL|F_RED, 64'h5555, 3'd0, 3'd0, 64'h0, 4'd2, 1'b1, 4'd0, 64'h0, 1'b0, 3'd2, 64'h2000);
        add(0, 64'h0, 3'd0, 3'd0, 64'h0, 4'd0, 1'b0, 4'd0, 64'h0, 1'b0, 3'd1, 64'h0);
        add(F_CTRL|F_CALL, 64'h6000, 3'd0, 3'd0, 64'h0, 4'd0, 1'b1, 4'd1, 64'h6000, 1'b0, 3'd1, 64'h0);
        add(F_RED|F_ACALL, 64'h0, 3'd0, 3'd1, 64'h7000, 4'd1, 1'b1, 4'd0, 64'h0, 1'b0, 3'd2, 64'h6000);
        add(F_RST, 64'h0, 3'd0, 3'd0, 64'h0, 4'd0, 1'b0, 4'd0, 64'h0, 1'b0, 3'd0, 64'h0);
        add(0, 64'h0, 3'd0, 3'd0, 64'h0, 4'd0, 1'b0, 4'd0, 64'h0, 1'b0, 3'd0, 64'h0);

        @(posedge clk); #1;
        mem_clr = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            reset   = (v.flags & F_RST) != 0;
            ctrl_f  = (v.flags & F_CTRL) != 0;
            call_f  = (v.flags & F_CALL) != 0;
            ret_f   = (v.flags & F_RET) != 0;
            res_e   = (v.flags & F_RES) != 0;
            red_e   = (v.flags & F_RED) != 0;
            acall_e = (v.flags & F_ACALL) != 0;
            aret_e  = (v.flags & F_ARET) != 0;
            stall_f = 1'b0;
            link_f = v.linkf; res_tag = v.rtag; red_tag = v.dtag; link_e = v.linke;
            @(negedge clk);
            if ((v.flags & F_RST) == 0) begin
                check($sformatf("vec%0d_ptr", i), 64'(ptr), 64'(v.e_ptr));
                check($sformatf("vec%0d_wren", i), 64'(wr_en), 64'(v.e_wren));
                if (v.e_wren) begin
                    check($sformatf("vec%0d_wridx", i), 64'(wr_idx), 64'(v.e_idx));
                    check($sformatf("vec%0d_wrdata", i), wr_data, v.e_data);
                end
                check($sformatf("vec%0d_stallreq", i), 64'(stall_req), 64'(v.e_stall));
                check($sformatf("vec%0d_tag", i), 64'(tag_f), 64'(v.e_tag));
                check($sformatf("vec%0d_raspcf", i), pcf, v.e_pcf);
            end
            @(posedge clk); #1;
        end

        // Six-entry stack: seven calls wrap 5->0, then returns wrap 0->5 with a resolve alongside.
        s6_reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            s6_ctrl = 1'b1; s6_call = 1'b1; s6_link = 64'hA000 + 64'(k);
            @(negedge clk);
            check($sformatf("s6_call%0d_wren", k), 64'(s6_wren), 64'd1);
            check($sformatf("s6_call%0d_wridx", k), 64'(s6_wridx), 64'((k + 1) % 6));
            check($sformatf("s6_call%0d_wrdata", k), s6_wrdata, 64'hA000 + 64'(k));
            @(posedge clk); #1;
            check($sformatf("s6_call%0d_ptr", k), 64'(s6_ptr), 64'((k + 1) % 6));
        end
        s6_call = 1'b0; s6_ret = 1'b1; s6_res = 1'b1;
        @(negedge clk);
        check("s6_ret_pcf", s6_pcf, 64'hA006);
        check("s6_ret_tag", 64'(s6_tag), 64'd7);
        @(posedge clk); #1;
        s6_res = 1'b0;
        check("s6_ret_ptr0", 64'(s6_ptr), 64'd0);
        check("s6_ret_stallreq", 64'(s6_stallreq), 64'd0);
        @(posedge clk); #1;
        s6_ctrl = 1'b0; s6_ret = 1'b0;
        check("s6_ret_ptr_wrap", 64'(s6_ptr), 64'd5);
        check("s6_full_stallreq", 64'(s6_stallreq), 64'd1);
        check("s6_full_tag", 64'(s6_tag), 64'd1);

        // Random traffic against the queue model.
        reset = 1'b1; ctrl_f = 1'b0; res_e = 1'b0; red_e = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < RS; i++) mmem[i] = mem[i];
        mptr = 0; ntag = 0; mrep = 1'b0; mrep_ptr = 0; mrep_link = 64'h0; q.delete();
        for (int n = 0; n < 3000; n++) begin
            ctrl_f  = ($urandom_range(0, 3) != 0);
            e_idx   = $urandom_range(0, 2);
            call_f  = (e_idx == 0);
            ret_f   = (e_idx == 1);
            stall_f = ($urandom_range(0, 4) == 0);
            link_f  = {$urandom, $urandom};
            link_e  = {$urandom, $urandom};
            if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
                res_e = 1'b1; res_tag = q[0].tag;
            end else begin
                res_e = 1'b0; res_tag = 3'($urandom);
            end
            ridx = -1; red_e = 1'b0; red_tag = 3'($urandom);
            acall_e = 1'($urandom); aret_e = 1'b0;
            if (!mrep && q.size() > int'(res_e) && $urandom_range(0, 5) == 0) begin
                ridx = $urandom_range(int'(res_e), q.size() - 1);
                red_e = 1'b1; red_tag = q[ridx].tag;
                e_idx = $urandom_range(0, 2);
                acall_e = (e_idx == 0); aret_e = (e_idx == 1);
            end
            fire = !mrep && ctrl_f && !stall_f && !red_e && (q.size() < CD);
            e_en = 1'b1; e_idx = 0; e_data = 64'h0;
            if (mrep) begin
                e_idx = mrep_ptr; e_data = mrep_link;
            end else if (red_e) begin
                e_idx = q[ridx].p; e_data = q[ridx].tos;
            end else if (fire && call_f) begin
                e_idx = (mptr + 1) % RS; e_data = link_f;
            end else begin
                e_en = 1'b0;
            end
            @(negedge clk);
            check("rnd_ptr", 64'(ptr), 64'(mptr));
            check("rnd_stallreq", 64'(stall_req), 64'((q.size() == CD) || mrep));
            check("rnd_tag", 64'(tag_f), 64'(ntag));
            check("rnd_raspcf", pcf, mmem[mptr]);
            check("rnd_wren", 64'(wr_en), 64'(e_en));
            if (e_en) begin
                check("rnd_wridx", 64'(wr_idx), 64'(e_idx));
                check("rnd_wrdata", wr_data, e_data);
            end
            if (mrep) begin
                mptr = mrep_ptr; mrep = 1'b0;
            end else if (red_e) begin
                c = q[ridx];
                while (q.size() > ridx + 1) void'(q.pop_back());
                ntag = (int'(c.tag) + 1) % CD;
                if (acall_e) begin
                    mptr = c.p; mrep = 1'b1; mrep_ptr = (c.p + 1) % RS; mrep_link = link_e;
                end else if (aret_e) begin
                    mptr = (c.p + RS - 1) % RS;
                end else begin
                    mptr = c.p;
                end
            end else if (fire) begin
                c.tag = 3'(ntag); c.p = mptr; c.tos = mmem[mptr];
                q.push_back(c);
                ntag = (ntag + 1) % CD;
                if (call_f) mptr = (mptr + 1) % RS;
                else if (ret_f) mptr = (mptr + RS - 1) % RS;
            end
            if (res_e) void'(q.pop_front());
            if (e_en) mmem[e_idx] = e_data;
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
